// File: rtl/clock_dp_ext.sv
// Time-of-day clock with sub-second divider, set-mode field editing, 12/24h display and alarm.
// Time fields and pulses are registered; display hour and PM flag are combinational from oHour.
module clock_dp_ext #(
  parameter  int CLK_HZ    = 100_000_000,
  parameter  int SUB_HZ    = 100,
  parameter  int INIT_HOUR = 12,
  parameter  int INIT_MIN  = 0,
  parameter  int INIT_SEC  = 0,
  localparam int SUB_W     = $clog2(SUB_HZ)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSet,
  input  logic             iHour_Up,
  input  logic             iHour_Down,
  input  logic             iMin_Up,
  input  logic             iMin_Down,
  input  logic             iSec_Up,
  input  logic             iSec_Down,
  input  logic             iMode12,
  input  logic             iAlarm_En,
  input  logic [4:0]       iAlarm_Hour,
  input  logic [5:0]       iAlarm_Min,
  output logic [SUB_W-1:0] omSec,
  output logic [5:0]       oSec,
  output logic [5:0]       oMin,
  output logic [4:0]       oHour,
  output logic [4:0]       oHour_Disp,
  output logic             oPM,
  output logic             omSec_Tick,
  output logic             oSec_Tick,
  output logic             oAlarm
);

  localparam int                DIV     = CLK_HZ / SUB_HZ;
  localparam int                DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_MAX = SUB_W'(SUB_HZ - 1);

  logic [DIV_W-1:0] divCnt;
  logic             subTick;
  logic             subWrap;
  logic             secWrap;
  logic             minWrap;
  logic             hourWrap;
  logic [5:0]       secNext;
  logic [5:0]       minNext;
  logic [4:0]       hourNext;
  logic             alarmHit;

  function automatic logic [5:0] edit60(input logic [5:0] v, input logic up, input logic dn);
    if (up == dn) return v;
    if (up)       return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] edit24(input logic [4:0] v, input logic up, input logic dn);
    if (up == dn) return v;
    if (up)       return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  assign subTick  = !iSet && (divCnt == DIV_MAX);
  assign subWrap  = (omSec == SUB_MAX);
  assign secWrap  = (oSec == 6'd59);
  assign minWrap  = (oMin == 6'd59);
  assign hourWrap = (oHour == 5'd23);

  // Values the seconds carry would produce; the alarm compares against these so it
  // fires on the same edge that makes the matching time visible.
  always_comb begin
    secNext  = secWrap ? 6'd0 : oSec + 6'd1;
    minNext  = oMin;
    hourNext = oHour;
    if (secWrap) begin
      minNext = minWrap ? 6'd0 : oMin + 6'd1;
      if (minWrap) begin
        hourNext = hourWrap ? 5'd0 : oHour + 5'd1;
      end
    end
  end

  assign alarmHit = iAlarm_En && secWrap &&
                    (hourNext == iAlarm_Hour) && (minNext == iAlarm_Min);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      divCnt     <= '0;
      omSec      <= '0;
      oSec       <= 6'(INIT_SEC);
      oMin       <= 6'(INIT_MIN);
      oHour      <= 5'(INIT_HOUR);
      omSec_Tick <= 1'b0;
      oSec_Tick  <= 1'b0;
      oAlarm     <= 1'b0;
    end else begin
      omSec_Tick <= 1'b0;
      oSec_Tick  <= 1'b0;
      oAlarm     <= 1'b0;
      if (iSet) begin
        divCnt <= '0;
        omSec  <= '0;
        oSec   <= edit60(oSec,  iSec_Up,  iSec_Down);
        oMin   <= edit60(oMin,  iMin_Up,  iMin_Down);
        oHour  <= edit24(oHour, iHour_Up, iHour_Down);
      end else if (subTick) begin
        divCnt     <= '0;
        omSec_Tick <= 1'b1;
        if (subWrap) begin
          omSec     <= '0;
          oSec      <= secNext;
          oMin      <= minNext;
          oHour     <= hourNext;
          oSec_Tick <= 1'b1;
          oAlarm    <= alarmHit;
        end else begin
          omSec <= omSec + SUB_W'(1);
        end
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    oHour_Disp = oHour;
    if (iMode12) begin
      if (oHour == 5'd0) begin
        oHour_Disp = 5'd12;
      end else if (oHour > 5'd12) begin
        oHour_Disp = oHour - 5'd12;
      end
    end
  end

  assign oPM = (oHour >= 5'd12);

endmodule

// File: tb/tb_clock_dp_ext.sv
// Randomized and directed bench for clock_dp_ext against a time-of-day model kept in tenths of a second.
module tb_clock_dp_ext;

  localparam int DIV = 100;
  localparam int DAY = 864000;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iSet = 1'b0;
  logic       iHour_Up = 1'b0, iHour_Down = 1'b0;
  logic       iMin_Up = 1'b0, iMin_Down = 1'b0;
  logic       iSec_Up = 1'b0, iSec_Down = 1'b0;
  logic       iMode12 = 1'b0;
  logic       iAlarm_En = 1'b0;
  logic [4:0] iAlarm_Hour = 5'd0;
  logic [5:0] iAlarm_Min = 6'd0;
  logic [3:0] omSec;
  logic [5:0] oSec, oMin;
  logic [4:0] oHour, oHour_Disp;
  logic       oPM, omSec_Tick, oSec_Tick, oAlarm;

  clock_dp_ext #(
    .CLK_HZ(1000), .SUB_HZ(10), .INIT_HOUR(12), .INIT_MIN(0), .INIT_SEC(0)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iSet(iSet),
    .iHour_Up(iHour_Up), .iHour_Down(iHour_Down),
    .iMin_Up(iMin_Up), .iMin_Down(iMin_Down),
    .iSec_Up(iSec_Up), .iSec_Down(iSec_Down),
    .iMode12(iMode12), .iAlarm_En(iAlarm_En),
    .iAlarm_Hour(iAlarm_Hour), .iAlarm_Min(iAlarm_Min),
    .omSec(omSec), .oSec(oSec), .oMin(oMin), .oHour(oHour),
    .oHour_Disp(oHour_Disp), .oPM(oPM),
    .omSec_Tick(omSec_Tick), .oSec_Tick(oSec_Tick), .oAlarm(oAlarm)
  );

  always #5 iClk = ~iClk;

  int nTests = 0;
  int nFail  = 0;

  // Model: time of day in tenths of a second, cycles elapsed since the divider last restarted.
  int mT;
  int mPh;
  bit eMs, eSt, eAl;
  int alarmSeen;
  logic [17:0] alarmAt;

  logic [31:0] gotVec;
  assign gotVec = {2'b00, oHour, oMin, oSec, omSec, omSec_Tick, oSec_Tick, oAlarm, oHour_Disp, oPM};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expVec();
    int h, m, s, sub, d;
    h   = mT / 36000;
    m   = (mT / 600) % 60;
    s   = (mT / 10) % 60;
    sub = mT % 10;
    d   = iMode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {2'b00, 5'(h), 6'(m), 6'(s), 4'(sub), eMs, eSt, eAl, 5'(d), 1'(h >= 12)};
  endfunction

  function automatic void modelReset();
    mT  = 12 * 36000;
    mPh = 0;
    eMs = 0; eSt = 0; eAl = 0;
  endfunction

  function automatic void modelEdge();
    int h, m, s;
    eMs = 0; eSt = 0; eAl = 0;
    if (iSet) begin
      h = mT / 36000;
      m = (mT / 600) % 60;
      s = (mT / 10) % 60;
      if (iHour_Up != iHour_Down) h = iHour_Up ? (h + 1) % 24 : (h + 23) % 24;
      if (iMin_Up  != iMin_Down)  m = iMin_Up  ? (m + 1) % 60 : (m + 59) % 60;
      if (iSec_Up  != iSec_Down)  s = iSec_Up  ? (s + 1) % 60 : (s + 59) % 60;
      mT  = ((h * 60 + m) * 60 + s) * 10;
      mPh = 0;
    end else begin
      mPh++;
      if (mPh == DIV) begin
        mPh = 0;
        mT  = (mT + 1) % DAY;
        eMs = 1;
        if (mT % 10 == 0) begin
          eSt = 1;
          eAl = iAlarm_En && (mT / 10 == int'(iAlarm_Hour) * 3600 + int'(iAlarm_Min) * 60);
        end
      end
    end
  endfunction

  task automatic step();
    modelEdge();
    @(posedge iClk);
    #1;
    checkVal("state", gotVec, expVec());
    if (oAlarm) begin
      alarmSeen++;
      alarmAt = {oHour, oMin, oSec, oSec_Tick};
    end
  endtask

  task automatic clearEdits();
    iHour_Up = 0; iHour_Down = 0; iMin_Up = 0; iMin_Down = 0; iSec_Up = 0; iSec_Down = 0;
  endtask

  // Enters set mode and presses Up on every field still short of its target; stays in set mode.
  task automatic setTime(input int h, input int m, input int s);
    iSet = 1;
    clearEdits();
    step();
    for (int i = 0; i < 70; i++) begin
      iHour_Up = (mT / 36000 != h);
      iMin_Up  = ((mT / 600) % 60 != m);
      iSec_Up  = ((mT / 10) % 60 != s);
      if (!(iHour_Up || iMin_Up || iSec_Up)) break;
      step();
    end
    clearEdits();
    checkVal("set_time", {15'd0, oHour, oMin, oSec}, {15'd0, 5'(h), 6'(m), 6'(s)});
  endtask

  task automatic firstTick(input string tag);
    int first = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (omSec_Tick && first == 0) begin
        first = k;
        checkVal({tag, "_msec"}, {28'd0, omSec}, 32'd1);
      end
    end
    checkVal(tag, first, DIV);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", nTests);
    $fatal(1);
  end

  initial begin
    int hrs [4] = '{0, 12, 13, 23};
    int disp[4] = '{12, 12, 1, 11};
    int pm  [4] = '{0, 1, 1, 1};

    modelReset();
    alarmSeen = 0;
    alarmAt   = '0;
    #2 iRst = 0;
    #1 checkVal("rst_vals", gotVec, expVec());
    repeat (2) @(posedge iClk);
    #1 checkVal("rst_hold", gotVec, expVec());
    @(negedge iClk) iRst = 1;
    firstTick("first_tick");

    // Full-day rollover in one edge.
    setTime(23, 59, 59);
    iSet = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (k == 999) checkVal("pm_before", {31'd0, oPM}, 32'd1);
      if (k == 1000)
        checkVal("rollover", {9'd0, oHour, oMin, oSec, omSec, oSec_Tick, oPM},
                 {9'd0, 5'd0, 6'd0, 6'd0, 4'd0, 1'b1, 1'b0});
    end

    // Set-mode freezing and wrap-without-carry edits.
    setTime(0, 59, 30);
    iSet = 0;
    repeat (400) step();
    checkVal("msec_run", {28'd0, omSec}, 32'd4);
    iSet = 1;
    step();
    checkVal("msec_frozen", {28'd0, omSec}, 32'd0);
    repeat (5) step();
    checkVal("frozen_time", {11'd0, oHour, oMin, oSec, omSec}, {11'd0, 5'd0, 6'd59, 6'd30, 4'd0});
    iMin_Up = 1;
    step();
    iMin_Up = 0;
    checkVal("min_wrap", {15'd0, oHour, oMin, oSec}, {15'd0, 5'd0, 6'd0, 6'd30});
    iSec_Down = 1;
    repeat (30) step();
    checkVal("sec_zero", {26'd0, oSec}, 32'd0);
    step();
    iSec_Down = 0;
    checkVal("sec_down_wrap", {20'd0, oMin, oSec}, {20'd0, 6'd0, 6'd59});
    iHour_Up = 1; iHour_Down = 1;
    step();
    clearEdits();
    checkVal("hour_updown", {27'd0, oHour}, 32'd0);

    // 12-hour display mapping.
    iMode12 = 1;
    for (int i = 0; i < 4; i++) begin
      setTime(hrs[i], 0, 0);
      checkVal("disp12", {26'd0, oHour_Disp, oPM}, {26'd0, 5'(disp[i]), 1'(pm[i])});
    end
    iMode12 = 0;

    // Alarm fires from a run-mode carry only.
    iAlarm_En = 1; iAlarm_Hour = 5'd7; iAlarm_Min = 6'd30;
    setTime(7, 29, 59);
    iSet = 0;
    alarmSeen = 0;
    repeat (1100) step();
    checkVal("alarm_count", alarmSeen, 1);
    checkVal("alarm_at", {14'd0, alarmAt}, {14'd0, 5'd7, 6'd30, 6'd0, 1'b1});
    setTime(7, 29, 59);
    alarmSeen = 0;
    setTime(7, 30, 0);
    repeat (3) step();
    checkVal("alarm_set_edit", alarmSeen, 0);

    // Asynchronous reset landing on a pending seconds/minutes/hours carry.
    setTime(10, 59, 59);
    iSet = 0;
    for (int k = 0; k < 1200; k++) begin
      if (mPh == DIV - 1 && mT % 10 == 9) break;
      step();
    end
    #3 iRst = 0;
    modelReset();
    #1 checkVal("rst_async", gotVec, expVec());
    @(posedge iClk);
    #1 checkVal("rst_no_tick", gotVec, expVec());
    @(negedge iClk) iRst = 1;
    firstTick("tick_after_rst");

    // Randomized runs around random alarm targets with stray edits and short set bursts.
    for (int r = 0; r < 10; r++) begin
      int ah, am;
      ah = $urandom_range(0, 23);
      am = $urandom_range(0, 59);
      iAlarm_En   = ($urandom_range(0, 3) != 0);
      iAlarm_Hour = 5'(ah);
      iAlarm_Min  = 6'(am);
      iMode12     = 1'($urandom_range(0, 1));
      setTime((am == 0) ? (ah + 23) % 24 : ah, (am + 59) % 60, $urandom_range(58, 59));
      iSet = 0;
      for (int k = 0; k < 2500; k++) begin
        iHour_Up   = 1'($urandom_range(0, 1));
        iHour_Down = 1'($urandom_range(0, 1));
        iMin_Up    = 1'($urandom_range(0, 1));
        iMin_Down  = 1'($urandom_range(0, 1));
        iSec_Up    = 1'($urandom_range(0, 1));
        iSec_Down  = 1'($urandom_range(0, 1));
        iSet       = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 499) == 0) iMode12 = ~iMode12;
        step();
      end
      iSet = 0;
      clearEdits();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
